// File: rtl/puf_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF compare block.
package puf_pkg;

  localparam int WINDOW_CYCLES_DEF = 1024;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF         = 16;
  localparam int CHAL_W            = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } puf_state_t;

endpackage

// File: rtl/puf_edge_counter.sv
// Synchronizes one asynchronous RO output, detects rising edges and counts
// them with saturation while cnt_en is high.
module puf_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  // SYNC_STAGES must be at least 2 for metastability protection.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign cnt  = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (clr) begin
        cnt_q <= '0;
      end else if (cnt_en && rise && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/puf_ro_compare.sv
// Ring-oscillator PUF: runs two ROs for a settle phase, counts their edges over
// a fixed window and reports which one is faster.
module puf_ro_compare
  import puf_pkg::*;
#(
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic              busy,
  output logic [CHAL_W-1:0] ro_challenge,
  output logic              ro_en,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic              resp_tie,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  localparam int MAXC = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  puf_state_t        state, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              accept;
  logic              has_result_q;

  // Response handshake: resp_valid is held with stable payload from entry to
  // DONE until the cycle where resp_valid && resp_ready; that edge returns to
  // IDLE. resp_ready without resp_valid is ignored.
  always_comb begin
    state_d = state;
    timer_d = timer_q;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SETTLE;
          timer_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = MEASURE;
          timer_d = WINDOW_LOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      MEASURE: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer_q      <= '0;
      ro_challenge <= '0;
      has_result_q <= 1'b0;
    end else begin
      state   <= state_d;
      timer_q <= timer_d;
      if (accept) ro_challenge <= challenge;
      // Result flags are qualified so reset and in-flight phases report 0.
      if (accept) begin
        has_result_q <= 1'b0;
      end else if ((state == MEASURE) && (state_d == DONE)) begin
        has_result_q <= 1'b1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign ro_en      = (state == SETTLE) || (state == MEASURE);
  assign resp_valid = (state == DONE);
  assign resp_bit   = has_result_q && (cnt_a > cnt_b);
  assign resp_tie   = has_result_q && (cnt_a == cnt_b);

  puf_edge_counter #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .rst    (rst),
    .ro     (ro_a),
    .clr    (accept),
    .cnt_en (state == MEASURE),
    .cnt    (cnt_a)
  );

  puf_edge_counter #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .rst    (rst),
    .ro     (ro_b),
    .clr    (accept),
    .cnt_en (state == MEASURE),
    .cnt    (cnt_b)
  );

endmodule

// File: tb/tb_puf_ro_compare.sv
// Bench for puf_ro_compare: table-driven measurements with a response
// scoreboard, plus directed backpressure, reset and gating sequences.
module tb_puf_ro_compare;

  localparam int WIN = 64;
  localparam int SET = 4;
  localparam int LAT = 1 + SET + WIN;

  typedef struct {
    logic [5:0] chal;
    int         a_lo, a_hi, b_lo, b_hi;
    logic       rbit, rtie, sat;
  } exp_t;

  typedef struct {
    int   a_per, b_per;
    exp_t e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] challenge = '0;
  logic       resp_ready = 1'b1;
  logic       ro_a = 1'b0, ro_b = 1'b0;
  logic       busy, ro_en, resp_valid, resp_bit, resp_tie;
  logic [5:0] ro_challenge;
  logic [7:0] cnt_a, cnt_b;
  logic       busy_s, ro_en_s, resp_valid_s, resp_bit_s, resp_tie_s;
  logic [5:0] ro_challenge_s;
  logic [3:0] cnt_a_s, cnt_b_s;

  int   a_per = 0, b_per = 0, a_ph = 0, b_ph = 0;
  logic a_lvl = 1'b0, b_lvl = 1'b0;
  int   checks = 0, errors = 0;
  exp_t exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  puf_ro_compare #(.WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy),
    .ro_challenge(ro_challenge), .ro_en(ro_en), .ro_a(ro_a), .ro_b(ro_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
    .resp_tie(resp_tie), .cnt_a(cnt_a), .cnt_b(cnt_b));

  puf_ro_compare #(.WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .busy(busy_s),
    .ro_challenge(ro_challenge_s), .ro_en(ro_en_s), .ro_a(ro_a), .ro_b(ro_b),
    .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_bit(resp_bit_s),
    .resp_tie(resp_tie_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s));

  // RO models: period in clk cycles, 0 = hold at *_lvl (also realigns phase).
  always @(negedge clk) begin
    if (a_per == 0) begin a_ph = 0; ro_a = a_lvl; end
    else begin a_ph = a_ph + 1; if (a_ph >= a_per / 2) begin a_ph = 0; ro_a = ~ro_a; end end
    if (b_per == 0) begin b_ph = 0; ro_b = b_lvl; end
    else begin b_ph = b_ph + 1; if (b_ph >= b_per / 2) begin b_ph = 0; ro_b = ~ro_b; end end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic quiet_ro();
    a_per = 0; b_per = 0; a_lvl = 1'b0; b_lvl = 1'b0;
    tick(4);
  endtask

  // ---------------- driver ----------------
  // Starts a measurement, pushes its expectation, waits for resp_valid and
  // scores the response. Leaves the FSM in DONE.
  task automatic measure(input int ap, input int bp, input exp_t e, input logic gate_only);
    int   n;
    exp_t x;
    quiet_ro();
    a_per = ap; b_per = bp;
    exp_q.push_back(e);
    start = 1'b1; challenge = e.chal;
    @(posedge clk); #1;
    n = 1;
    start = 1'b0;
    challenge = 6'($urandom_range(0, 63));
    if (gate_only) begin a_lvl = 1'b1; b_lvl = 1'b1; end
    chk("ro_en_settle", int'(ro_en), 1);
    while (!resp_valid && n < LAT + 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, LAT);
    x = exp_q.pop_front();
    chk("ro_challenge", int'(ro_challenge), int'(x.chal));
    chk_rng("cnt_a", int'(cnt_a), x.a_lo, x.a_hi);
    chk_rng("cnt_b", int'(cnt_b), x.b_lo, x.b_hi);
    chk("resp_bit", int'(resp_bit), int'(x.rbit));
    chk("resp_tie", int'(resp_tie), int'(x.rtie));
    chk("ro_en_done", int'(ro_en), 0);
    if (x.sat) begin
      chk("sat_cnt_a", int'(cnt_a_s), 15);
      chk_rng("sat_cnt_b", int'(cnt_b_s), x.b_lo, x.b_hi);
      chk("sat_resp_bit", int'(resp_bit_s), 1);
    end
  endtask

  task automatic handshake(input exp_t e);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_hs", int'(resp_valid), 0);
    chk("busy_after_hs", int'(busy), 0);
    chk_rng("hold_cnt_a", int'(cnt_a), e.a_lo, e.a_hi);
    chk("hold_resp_tie", int'(resp_tie), int'(e.rtie));
  endtask

  // ---------------- test ----------------
  vec_t vecs[4];
  exp_t eb, eg;
  logic [7:0] cap_a, cap_b;
  int   seen;

  initial begin
    vecs[0] = '{4, 6, '{6'h2A, 15, 17, 9, 11, 1'b1, 1'b0, 1'b1}};  // basic + saturation
    vecs[1] = '{4, 4, '{6'h15, 15, 17, 15, 17, 1'b0, 1'b1, 1'b0}};  // tie
    vecs[2] = '{6, 4, '{6'h3F, 9, 11, 15, 17, 1'b0, 1'b0, 1'b0}};   // swapped
    vecs[3] = '{2, 8, '{6'h01, 31, 33, 7, 9, 1'b1, 1'b0, 1'b0}};    // fast A

    // reset state
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_resp_tie", int'(resp_tie), 0);
    chk("rst_ro_challenge", int'(ro_challenge), 0);
    rst = 1'b0;
    tick(2);

    // resp_ready while idle does nothing
    resp_ready = 1'b1;
    tick(3);
    chk("idle_ready_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      measure(vecs[i].a_per, vecs[i].b_per, vecs[i].e, 1'b0);
      handshake(vecs[i].e);
    end

    // backpressure: hold 20 cycles, ignored start pulse, then release
    resp_ready = 1'b0;
    eb = vecs[0].e;
    measure(4, 6, eb, 1'b0);
    cap_a = cnt_a; cap_b = cnt_b;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start = 1'b1; challenge = 6'h11; end
      if (i == 6) start = 1'b0;
      @(posedge clk); #1;
      if (i % 4 == 0 || i == 6) begin
        chk("bp_valid", int'(resp_valid), 1);
        chk("bp_cnt_a", int'(cnt_a), int'(cap_a));
        chk("bp_cnt_b", int'(cnt_b), int'(cap_b));
        chk("bp_chal", int'(ro_challenge), int'(eb.chal));
        chk("bp_bit", int'(resp_bit), 1);
      end
    end
    handshake(eb);

    // reset in the middle of MEASURE
    quiet_ro();
    a_per = 4; b_per = 6;
    start = 1'b1; challenge = 6'h0C;
    @(posedge clk); #1;
    start = 1'b0;
    tick(29);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ro_en", int'(ro_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cnt_a", int'(cnt_a), 0);
    chk("mid_rst_cnt_b", int'(cnt_b), 0);
    chk("mid_rst_chal", int'(ro_challenge), 0);
    tick(2);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("no_valid_after_rst", seen, 0);
    measure(4, 6, vecs[0].e, 1'b0);
    handshake(vecs[0].e);

    // gating: one edge per RO, only early in SETTLE
    eg = '{6'h2A, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
    measure(0, 0, eg, 1'b1);
    handshake(eg);
    a_lvl = 1'b0; b_lvl = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_ro_compare.md
PUF_RO_COMPARE -- requirements
Module: puf_ro_compare

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1024: number of clk cycles during which RO edges are counted.
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles the ROs run before counting starts.
REQ-003 Parameter CNT_W, default 16: width of each edge counter.
REQ-004 Parameter SYNC_STAGES, default 2: flip-flops in each RO-input synchronizer (minimum 2).
REQ-005 Ports are as follows; the block has one clock, and reset is asynchronous and active-high.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one measurement.
- challenge  input  6  challenge applied to both ROs.
- busy  output  1  measurement in progress.
- ro_challenge  output  6  latched challenge driven to both puf_cro instances.
- ro_en  output  1  enable for both puf_cro instances.
- ro_a  input  1  asynchronous output of RO A.
- ro_b  input  1  asynchronous output of RO B.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_bit  output  1  1 when cnt_a > cnt_b.
- resp_tie  output  1  1 when cnt_a == cnt_b.
- cnt_a  output  CNT_W  final edge count of RO A.
- cnt_b  output  CNT_W  final edge count of RO B.

Function
REQ-006 The FSM SHALL have exactly four states, IDLE, SETTLE, MEASURE and DONE, and SHALL reset into IDLE.
REQ-007 In IDLE, start=1 SHALL latch challenge into ro_challenge, clear both counters and move to SETTLE on the next edge.
REQ-008 start SHALL be ignored in every state other than IDLE, and the challenge input SHALL have no effect outside that accepting cycle.
REQ-009 ro_en SHALL be 1 in SETTLE and MEASURE only, and 0 in IDLE and DONE.
REQ-010 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-011 MEASURE SHALL last exactly WINDOW_CYCLES cycles, then go to DONE.
REQ-012 Each RO input SHALL pass through a SYNC_STAGES flip-flop synchronizer followed by rising-edge detection.
REQ-013 A detected edge SHALL increment its counter only in a MEASURE cycle.
REQ-014 Edges detected in SETTLE, DONE or IDLE SHALL NOT be counted.
REQ-015 Each counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-016 busy SHALL be 1 in SETTLE, MEASURE and DONE.
REQ-017 In DONE, resp_valid SHALL be 1, and resp_bit, resp_tie, cnt_a and cnt_b SHALL be stable until the handshake completes.
REQ-018 resp_bit SHALL be (cnt_a > cnt_b), and resp_tie SHALL be (cnt_a == cnt_b); a tie gives resp_bit=0.
REQ-019 When resp_valid and resp_ready are both 1, the FSM SHALL return to IDLE on that edge.
REQ-020 resp_ready asserted while resp_valid=0 SHALL have no effect.
REQ-021 In IDLE, cnt_a, cnt_b, resp_bit and resp_tie SHALL hold the last completed result.
REQ-022 The minimum start-to-resp_valid latency SHALL be 1+SETTLE_CYCLES+WINDOW_CYCLES cycles.

Reset
REQ-023 rst=1 SHALL asynchronously force the following, regardless of state, including mid-measurement:
- state IDLE;
- ro_en, busy, resp_valid, resp_bit and resp_tie to 0;
- cnt_a, cnt_b, ro_challenge, synchronizers and edge-detect registers to 0.
REQ-024 A measurement interrupted by reset SHALL NOT produce resp_valid after rst deasserts.

Structure
REQ-025 The state enum, the default values of WINDOW_CYCLES, SETTLE_CYCLES and CNT_W, and the challenge width (6) SHALL live in the shared package puf_pkg.
REQ-026 The synchronizer, edge detector and saturating counter SHALL form one sub-module, puf_edge_counter, instantiated twice (A and B).
REQ-027 The phase timer SHALL be a single down-counter shared by SETTLE and MEASURE.

Verification
REQ-028 The bench SHALL cover these directed scenarios (WINDOW_CYCLES=64, SETTLE_CYCLES=4, CNT_W=8):
- Basic: ro_a toggling at clk/4 and ro_b at clk/6, start with challenge=6'h2A, resp_ready=1 -> ro_challenge=6'h2A, resp_valid at cycle 69 after start, cnt_a=16±1, cnt_b=10±1, resp_bit=1.
- Tie and ordering: identical A/B stimulus -> resp_tie=1, resp_bit=0; swapping the A/B rates -> resp_bit=0, resp_tie=0.
- Saturation: CNT_W=4 with ro_a at clk/4 -> cnt_a=15 with no wrap, resp_bit=1.
- Backpressure: resp_ready=0 for 20 cycles -> resp_valid and outputs held stable, and a start pulse in that interval is ignored; resp_ready=1 -> IDLE on the next edge.
- Reset mid-MEASURE: rst pulsed at cycle 30 -> ro_en=0 and counters=0 immediately, no resp_valid; a new start then completes normally.
- Gating: RO edges supplied only during SETTLE -> cnt_a=cnt_b=0, resp_tie=1.
